// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_op_e    : E-stage operation codes carried on the 3-bit op bus
//   md_state_e : controller states
//   default latencies for multiply and divide
//   md_is_mul / md_is_div : op class helpers used by the controller
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational result generator for MULT/MULTU/DIV/DIVU.
// Ports:
//   op     in  3      operation code (md_op_e values)
//   a      in  WIDTH  rs operand (multiplicand / dividend)
//   b      in  WIDTH  rt operand (multiplier / divisor)
//   hi_res out WIDTH  upper product half or remainder
//   lo_res out WIDTH  lower product half or quotient
// Divide by zero yields lo=all ones, hi=dividend. Signed division runs on
// magnitudes, so most-negative / -1 naturally gives lo=most-negative, hi=0.
module md_compute
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_ua;
  logic [WIDTH-1:0]   w_ub;
  logic [WIDTH-1:0]   w_uq;
  logic [WIDTH-1:0]   w_ur;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  // Low 2*WIDTH bits of the product of sign-extended operands equal the
  // signed product, so both flavours use a plain unsigned multiplier.
  assign w_prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign w_a_neg = (op == MD_DIV) && a[WIDTH-1];
  assign w_b_neg = (op == MD_DIV) && b[WIDTH-1];
  assign w_ua    = w_a_neg ? -a : a;
  assign w_ub    = w_b_neg ? -b : b;
  assign w_uq    = (w_ub == '0) ? '0 : (w_ua / w_ub);
  assign w_ur    = (w_ub == '0) ? '0 : (w_ua % w_ub);
  assign w_q     = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
  assign w_r     = w_a_neg ? -w_ur : w_ur;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (op)
      MD_MULT: begin
        hi_res = w_prod_s[2*WIDTH-1:WIDTH];
        lo_res = w_prod_s[WIDTH-1:0];
      end
      MD_MULTU: begin
        hi_res = w_prod_u[2*WIDTH-1:WIDTH];
        lo_res = w_prod_u[WIDTH-1:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b == '0) begin
          hi_res = a;
          lo_res = '1;
        end else begin
          hi_res = w_r;
          lo_res = w_q;
        end
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed when the op is accepted and held in a pending
// pair; a down-counter models the latency and the pair is committed to
// hi/lo on the edge busy falls.
// Ports:
//   clk    in  1      clock, rising edge
//   reset  in  1      synchronous active-high reset
//   start  in  1      request valid this cycle
//   op     in  3      md_op_e operation code
//   rs_val in  WIDTH  operand A / MT source
//   rt_val in  WIDTH  operand B
//   cancel in  1      flush of the in-flight op (only with MDU_CANCEL_EN)
//   busy   out 1      operation in flight
//   hi/lo  out WIDTH  architectural HI/LO
// Optional: define MDU_CANCEL_EN to add the cancel port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | no op in flight; accepts MULT/DIV starts and MTHI/MTLO
// MD_RUN  | result pending; counter counts down, commit at zero
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  md_state_e        r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [WIDTH-1:0] r_pend_hi, w_pend_hi_nxt;
  logic [WIDTH-1:0] r_pend_lo, w_pend_lo_nxt;
  logic [WIDTH-1:0] r_hi,      w_hi_nxt;
  logic [WIDTH-1:0] r_lo,      w_lo_nxt;
  logic [WIDTH-1:0] w_hi_res;
  logic [WIDTH-1:0] w_lo_res;
  logic             w_cancel;

`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  md_compute #(.WIDTH(WIDTH)) u_compute (
    .op     (op),
    .a      (rs_val),
    .b      (rt_val),
    .hi_res (w_hi_res),
    .lo_res (w_lo_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= MD_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    case (r_state)
      MD_IDLE: begin
        if (start) begin
          // MT writes take effect regardless of cancel; MULT/DIV starts
          // are dropped when the instruction is being flushed.
          if (op == MD_MTHI) begin
            w_hi_nxt = rs_val;
          end else if (op == MD_MTLO) begin
            w_lo_nxt = rs_val;
          end else if (!w_cancel && (md_is_mul(op) || md_is_div(op))) begin
            w_pend_hi_nxt = w_hi_res;
            w_pend_lo_nxt = w_lo_res;
            w_cnt_nxt     = md_is_mul(op) ? CNT_W'(MULT_CYCLES - 1)
                                          : CNT_W'(DIV_CYCLES - 1);
            w_state_nxt   = MD_RUN;
          end
        end
      end
      MD_RUN: begin
        if (w_cancel) begin
          w_state_nxt   = MD_IDLE;
          w_cnt_nxt     = '0;
          w_pend_hi_nxt = '0;
          w_pend_lo_nxt = '0;
        end else if (r_cnt == '0) begin
          w_hi_nxt      = r_pend_hi;
          w_lo_nxt      = r_pend_lo;
          w_state_nxt   = MD_IDLE;
          w_pend_hi_nxt = '0;
          w_pend_lo_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
      end
    endcase
  end

  assign busy = (r_state == MD_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit with hand-computed expectations.
// Also counts starts issued while busy (hazard-controller violations).
module tb_mult_div_unit;
  import md_pkg::*;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int n_tests;
  int n_fail;
  int n_viol;

  mult_div_unit #(.WIDTH(WIDTH), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
`ifdef MDU_CANCEL_EN
    .cancel (cancel),
`endif
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && start && busy) n_viol <= n_viol + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, then count busy cycles and check the committed HI/LO.
  // hi/lo must stay at their pre-op values for the whole busy window.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int          n;
    logic        stale_ok;
    logic [31:0] hi0;
    logic [31:0] lo0;
    @(negedge clk);
    hi0    = hi;
    lo0    = lo;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start    = 1'b0;
    op       = MD_NONE;
    n        = 0;
    stale_ok = 1'b1;
    while (busy && n < 100) begin
      n++;
      if (hi !== hi0 || lo !== lo0) stale_ok = 1'b0;
      @(negedge clk);
    end
    check_eq({tag, " busy_cycles"}, 64'(n), 64'(exp_cyc));
    check_eq({tag, " hilo_held"}, 64'(stale_ok), 64'd1);
    check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    n_viol  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    op      = MD_NONE;
    rs_val  = '0;
    rt_val  = '0;
    cancel  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset hi", 64'(hi), 64'd0);
    check_eq("reset lo", 64'(lo), 64'd0);
    check_eq("reset busy", 64'(busy), 64'd0);
    reset = 1'b0;

    run_op("mult",   MD_MULT,  32'hFFFF_FFFF, 32'h2,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu",  MD_MULTU, 32'hFFFF_FFFF, 32'h2,         5,  32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",    MD_DIV,   32'hFFFF_FFF9, 32'h2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_nb", MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu",   MD_DIVU,  32'hFFFF_FFF9, 32'h2,         10, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("divu0",  MD_DIVU,  32'h0000_0007, 32'h0,         10, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div0",   MD_DIV,   32'hFFFF_FFF9, 32'h0,         10, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ov", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

    // MTHI / MTLO: zero latency, busy never rises.
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; rs_val = 32'h1234;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    check_eq("mthi hi", 64'(hi), 64'h1234);
    check_eq("mthi busy", 64'(busy), 64'd0);
    start = 1'b1; op = MD_MTLO; rs_val = 32'h5678;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    check_eq("mtlo lo", 64'(lo), 64'h5678);
    check_eq("mtlo hi", 64'(hi), 64'h1234);

    // Unknown op with start: nothing happens.
    start = 1'b1; op = 3'd7; rs_val = 32'hDEAD; rt_val = 32'h1;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    check_eq("badop busy", 64'(busy), 64'd0);
    check_eq("badop hi", 64'(hi), 64'h1234);
    check_eq("badop lo", 64'(lo), 64'h5678);

    // Start while busy is ignored; the original MULT commits on time.
    start = 1'b1; op = MD_MULT; rs_val = 32'd3; rt_val = 32'd4;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 2) begin
        start = 1'b1; op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
      end else begin
        start = 1'b0; op = MD_NONE;
      end
      @(negedge clk);
    end
    start = 1'b0; op = MD_NONE;
    check_eq("busy_start cycles", 64'(n), 64'd5);
    check_eq("busy_start hi", 64'(hi), 64'd0);
    check_eq("busy_start lo", 64'(lo), 64'd12);
    check_eq("hazard violations", 64'(n_viol), 64'd1);
    repeat (12) @(negedge clk);
    check_eq("busy_start no_late", 64'(lo), 64'd12);

    // Reset during RUN aborts; no commit afterwards.
    start = 1'b1; op = MD_MTHI; rs_val = 32'hAAAA;
    @(negedge clk);
    start = 1'b1; op = MD_DIV; rs_val = 32'd50; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_run hi", 64'(hi), 64'd0);
    check_eq("rst_run lo", 64'(lo), 64'd0);
    check_eq("rst_run busy", 64'(busy), 64'd0);
    repeat (12) @(negedge clk);
    check_eq("rst_run no_commit hi", 64'(hi), 64'd0);
    check_eq("rst_run no_commit lo", 64'(lo), 64'd0);

`ifdef MDU_CANCEL_EN
    start = 1'b1; op = MD_MTLO; rs_val = 32'h77;
    @(negedge clk);
    start = 1'b1; op = MD_MULT; rs_val = 32'd6; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_eq("cancel busy", 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    check_eq("cancel lo", 64'(lo), 64'h77);
    check_eq("cancel hi", 64'(hi), 64'd0);
    start = 1'b1; cancel = 1'b1; op = MD_DIV; rs_val = 32'd9; rt_val = 32'd2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = MD_NONE;
    check_eq("cancel_start busy", 64'(busy), 64'd0);
    start = 1'b1; cancel = 1'b1; op = MD_MTHI; rs_val = 32'h99;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = MD_NONE;
    check_eq("cancel_mthi hi", 64'(hi), 64'h99);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the next-generation 5-stage MIPS pipeline.
- Sits in the E stage beside the ALU. It serves MULT/MULTU/DIV/DIVU/MTHI/MTLO; MFHI/MFLO read the hi/lo outputs.
- Drives busy to the hazard controller, which stalls any D-stage MD-class instruction while start or busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles from accepted multiply to HI/LO commit (>=1).
- DIV_CYCLES, 10, cycles from accepted divide to HI/LO commit (>=1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage request valid for this cycle.
- op  in  3  operation code, values from md_pkg.
- rs_val  in  WIDTH  forwarded operand A (dividend / multiplicand / MT source).
- rt_val  in  WIDTH  forwarded operand B (divisor / multiplier).
- busy  out  1  an operation is in flight.
- hi  out  WIDTH  current HI register.
- lo  out  WIDTH  current LO register.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, cycle counter=0, pending result=0, state IDLE.
- States:
  - IDLE: start with op in {MULT,MULTU,DIV,DIVU} at edge t0 does three things: computes the result from rs_val/rt_val, latches it into a pending HI/LO pair, and loads counter with MULT_CYCLES-1 or DIV_CYCLES-1. It then goes to RUN with busy=1 from t0.
  - RUN: counter decrements each edge. At the edge where counter==0 it writes pending to hi/lo, sets busy=0 and returns to IDLE.
  - Net effect: busy is high for exactly N cycles, and new hi/lo are visible on the same edge that busy falls.
- MTHI/MTLO with start in IDLE: hi<=rs_val or lo<=rs_val at that edge. busy stays 0 (zero latency).
- start while RUN: ignored; no state change. This is a hazard-controller violation, and the bench flags it as an assertion.
- Unknown op values with start: no operation, no state change.
- hi/lo are not modified during RUN until commit, so MFHI/MFLO are stalled rather than fed stale data.
- Arithmetic:
  - MULT: signed WIDTH x WIDTH -> 2*WIDTH; hi=upper half, lo=lower half.
  - MULTU: same, unsigned.
  - DIV/DIVU: lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
- Divide by zero: lo=all ones, hi=rs_val. Applies to both signed and unsigned.
- Signed overflow (DIV of most-negative by -1): lo=most-negative, hi=0.
- reset during RUN: abort immediately. All state returns to reset values and the pending result is discarded.

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit), used when an exception or interrupt flushes the E-stage instruction.
  - cancel=1 in RUN: return to IDLE at that edge; busy=0 next cycle; hi/lo unchanged; pending discarded.
  - cancel together with start in IDLE: start is suppressed.
  - cancel is ignored while an MTHI/MTLO would otherwise write.
- Not defined: no cancel port; an in-flight op always commits.

Decomposition:
- md_pkg holds:
  - op encodings: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6;
  - state encoding IDLE/RUN;
  - default latency constants.
- Sub-module md_compute: purely combinational result generator (op, a, b -> hi_res, lo_res), including the divide-by-zero and overflow rules.
- mult_div_unit holds the FSM, counter and registers.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x2 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE on the edge busy falls.
- MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0. MTHI 0x1234 in IDLE -> hi=0x1234 next edge, busy stays 0.
- Start DIV, assert reset at cycle 4 -> hi=lo=0, busy=0 next cycle; no commit afterwards.
- MDU_CANCEL_EN: start MULT, cancel at cycle 2 -> busy=0 next cycle, hi/lo keep prior values. Start while busy -> ignored, original result commits on time.
